// File: rtl/tlc_pkg.sv
// Shared state codes, lamp encodings and the light decode for the traffic-light controller.
package tlc_pkg;

    localparam logic [2:0] ST_MAIN_G   = 3'd0;
    localparam logic [2:0] ST_MAIN_Y   = 3'd1;
    localparam logic [2:0] ST_ALLRED1  = 3'd2;
    localparam logic [2:0] ST_SIDE_G   = 3'd3;
    localparam logic [2:0] ST_SIDE_Y   = 3'd4;
    localparam logic [2:0] ST_ALLRED2  = 3'd5;
    localparam logic [2:0] ST_PED_WALK = 3'd6;

    typedef enum logic [2:0] {
        S_MAIN_G   = ST_MAIN_G,
        S_MAIN_Y   = ST_MAIN_Y,
        S_ALLRED1  = ST_ALLRED1,
        S_SIDE_G   = ST_SIDE_G,
        S_SIDE_Y   = ST_SIDE_Y,
        S_ALLRED2  = ST_ALLRED2,
        S_PED_WALK = ST_PED_WALK
    } tlc_state_e;

    // Lamp words are {R,Y,G}
    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    typedef struct packed {
        logic [2:0] main;
        logic [2:0] side;
    } lights_t;

    function automatic lights_t light_decode(tlc_state_e s);
        lights_t l;
        l.main = LIGHT_R;
        l.side = LIGHT_R;
        case (s)
            S_MAIN_G: l.main = LIGHT_G;
            S_MAIN_Y: l.main = LIGHT_Y;
            S_SIDE_G: l.side = LIGHT_G;
            S_SIDE_Y: l.side = LIGHT_Y;
            default:  ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Per-phase down counter in tick units; load wins over tick so entry-edge ticks are not counted.
module tlc_phase_timer #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expired,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = tick && (cnt == '0);

endmodule

// File: rtl/tlc_controller.sv
// Traffic-light controller: main road, side road, optional pedestrian phase (macro TLC_PED_EN).
// Lamps are registered decodes of the next state, so they change together with the state.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   MAIN_G    | main green; held at expiry until w (or ped_pend)
//   MAIN_Y    | main yellow
//   ALLRED1   | clearance before side green or walk
//   SIDE_G    | side green, fixed length
//   SIDE_Y    | side yellow
//   ALLRED2   | clearance before main green; also the recovery state
//   PED_WALK  | walk lamp on, both roads red
module tlc_controller
    import tlc_pkg::*;
#(
    parameter int GREEN_TICKS  = 4,
    parameter int SIDE_TICKS   = 3,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int PED_TICKS    = 5,
    parameter int CNT_W        = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       tick,
    input  logic       w,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] state
);

    tlc_state_e       state_q;
    tlc_state_e       state_nx;
    logic             load;
    logic             expired;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    lights_t          lights_nx;

    function automatic logic [CNT_W-1:0] phase_len(tlc_state_e s);
        case (s)
            S_MAIN_G:   return CNT_W'(GREEN_TICKS - 1);
            S_MAIN_Y:   return CNT_W'(YELLOW_TICKS - 1);
            S_SIDE_G:   return CNT_W'(SIDE_TICKS - 1);
            S_SIDE_Y:   return CNT_W'(YELLOW_TICKS - 1);
            S_PED_WALK: return CNT_W'(PED_TICKS - 1);
            default:    return CNT_W'(ALLRED_TICKS - 1);
        endcase
    endfunction

`ifdef TLC_PED_EN
    logic ped_pend;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        state_nx = state_q;
        case (state_q)
`ifdef TLC_PED_EN
            S_MAIN_G:   if (expired && (w || ped_pend)) state_nx = S_MAIN_Y;
            S_ALLRED1:  if (expired) state_nx = ped_pend ? S_PED_WALK : S_SIDE_G;
            S_PED_WALK: if (expired) state_nx = S_ALLRED2;
`else
            S_MAIN_G:   if (expired && w) state_nx = S_MAIN_Y;
            S_ALLRED1:  if (expired) state_nx = S_SIDE_G;
`endif
            S_MAIN_Y:   if (expired) state_nx = S_ALLRED1;
            S_SIDE_G:   if (expired) state_nx = S_SIDE_Y;
            S_SIDE_Y:   if (expired) state_nx = S_ALLRED2;
            S_ALLRED2:  if (expired) state_nx = S_MAIN_G;
            default:    state_nx = S_ALLRED2;
        endcase
    end

    assign load      = (state_nx != state_q);
    assign load_val  = phase_len(state_nx);
    assign lights_nx = light_decode(state_nx);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_MAIN_G;
            main_light <= LIGHT_G;
            side_light <= LIGHT_R;
        end else begin
            state_q    <= state_nx;
            main_light <= lights_nx.main;
            side_light <= lights_nx.side;
        end
    end

`ifdef TLC_PED_EN
    // A request arriving on the same edge that enters the walk phase stays pending.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ped_pend <= 1'b0;
            walk     <= 1'b0;
        end else begin
            ped_pend <= ped_req || (ped_pend && !(load && (state_nx == S_PED_WALK)));
            walk     <= (state_nx == S_PED_WALK);
        end
    end
`else
    assign walk = 1'b0;
`endif

    assign state = state_q;

    tlc_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(GREEN_TICKS - 1))
    ) u_timer (
        .clk      (Clock),
        .rst      (Reset),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .expired  (expired),
        .cnt      (cnt)
    );

endmodule

// File: tb/tb_tlc_controller.sv
// Scoreboard bench for tlc_controller: stimulus queues expected transitions, a monitor checks them.
module tb_tlc_controller;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
    localparam logic [2:0] MG = 3'd0, MY = 3'd1, AR1 = 3'd2, SG = 3'd3;
    localparam logic [2:0] SY = 3'd4, AR2 = 3'd5, PW = 3'd6;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       tick = 1'b1;
    logic       w = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_light, side_light, state;
    logic       walk;

    typedef struct {
        logic [2:0] st;
        logic [2:0] m;
        logic [2:0] s;
        logic       wk;
        int         dur;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;
    logic [2:0] mon_prev = 3'd0;
    int   mon_last = 0;

    tlc_controller dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .tick       (tick),
        .w          (w),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .state      (state)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [2:0] m, input logic [2:0] s,
                        input logic wk, input int dur);
        exp_t e;
        e.st = st; e.m = m; e.s = s; e.wk = wk; e.dur = dur;
        q.push_back(e);
    endtask

    // Monitor: legality of lamps every cycle, and every state change against the queue.
    always @(negedge Clock) begin
        #1;
        if (mon_en) begin
            n_vec++;
            if (!((main_light == R || side_light == R) &&
                  $onehot(main_light) && $onehot(side_light))) begin
                n_err++;
                $display("FAIL lamp_legal: got main=%b side=%b required one road red", main_light, side_light);
            end
            if (state != mon_prev) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_transition: got state %0d from %0d required no change", state, mon_prev);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (state != e.st || main_light != e.m || side_light != e.s ||
                        walk != e.wk || (cyc - mon_last) != e.dur) begin
                        n_err++;
                        $display("FAIL transition: got st=%0d main=%b side=%b walk=%b dur=%0d required st=%0d main=%b side=%b walk=%b dur=%0d",
                                 state, main_light, side_light, walk, cyc - mon_last,
                                 e.st, e.m, e.s, e.wk, e.dur);
                    end
                end
                mon_prev = state;
                mon_last = cyc;
            end
        end
    end

    task automatic reset_dut();
        @(negedge Clock);
        mon_en  = 1'b0;
        Reset   = 1'b1;
        w       = 1'b0;
        ped_req = 1'b0;
        tick    = 1'b1;
        @(negedge Clock);
        Reset    = 1'b0;
        mon_prev = 3'd0;
        mon_last = cyc;
        mon_en   = 1'b1;
    endtask

    task automatic drained(input string name);
        chk(name, q.size(), 0);
        q.delete();
    endtask

    task automatic check_idle(input string name);
        chk({name, "_state"}, int'(state), int'(MG));
        chk({name, "_main"}, int'(main_light), int'(G));
        chk({name, "_side"}, int'(side_light), int'(R));
        chk({name, "_walk"}, int'(walk), 0);
    endtask

    initial begin
        // Reset values while reset is held
        #12;
        check_idle("reset");
        chk("reset_cnt", int'(dut.cnt), 3);

        // 1: no demand, main green holds
        reset_dut();
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clock);
            if (k % 5 == 0) check_idle("hold");
        end
        drained("t1_drain");

        // 2: side demand, full 13-tick cycle
        reset_dut();
        w = 1'b1;
        push(MY,  Y, R, 1'b0, 4);
        push(AR1, R, R, 1'b0, 2);
        push(SG,  R, G, 1'b0, 1);
        push(SY,  R, Y, 1'b0, 3);
        push(AR2, R, R, 1'b0, 2);
        push(MG,  G, R, 1'b0, 1);
        repeat (13) @(negedge Clock);
        w = 1'b0;
        repeat (8) @(negedge Clock);
        drained("t2_drain");

        // w dropped before expiry cancels the change
        reset_dut();
        w = 1'b1;
        repeat (2) @(negedge Clock);
        w = 1'b0;
        repeat (8) @(negedge Clock);
        check_idle("w_cancel");
        drained("w_cancel_drain");

        // 4: tick every third cycle
        reset_dut();
        w = 1'b1;
        push(MY,  Y, R, 1'b0, 12);
        push(AR1, R, R, 1'b0, 6);
        push(SG,  R, G, 1'b0, 3);
        push(SY,  R, Y, 1'b0, 9);
        push(AR2, R, R, 1'b0, 6);
        push(MG,  G, R, 1'b0, 3);
        for (int k = 1; k <= 39; k++) begin
            tick = (k % 3 == 0);
            @(negedge Clock);
            if (k < 12) chk("slow_tick_cnt", int'(dut.cnt), 3 - k / 3);
        end
        w = 1'b0;
        tick = 1'b1;
        repeat (6) @(negedge Clock);
        drained("t4_drain");

        // 5: asynchronous reset in the middle of side green
        reset_dut();
        w = 1'b1;
        push(MY,  Y, R, 1'b0, 4);
        push(AR1, R, R, 1'b0, 2);
        push(SG,  R, G, 1'b0, 1);
        repeat (8) @(negedge Clock);
        drained("t5_drain");
        #2;
        mon_en = 1'b0;
        Reset  = 1'b1;
        #1;
        check_idle("async_rst");
        chk("async_rst_cnt", int'(dut.cnt), 3);

`ifdef TLC_PED_EN
        // 3: single ped pulse, walk phase, side never green
        reset_dut();
        push(MY,  Y, R, 1'b0, 4);
        push(AR1, R, R, 1'b0, 2);
        push(PW,  R, R, 1'b1, 1);
        push(AR2, R, R, 1'b0, 5);
        push(MG,  G, R, 1'b0, 1);
        for (int k = 1; k <= 22; k++) begin
            ped_req = (k == 1);
            @(negedge Clock);
        end
        check_idle("ped_after");
        drained("t3_drain");

        // 6: request held across the walk-entry edge stays pending
        reset_dut();
        push(MY,  Y, R, 1'b0, 4);
        push(AR1, R, R, 1'b0, 2);
        push(PW,  R, R, 1'b1, 1);
        push(AR2, R, R, 1'b0, 5);
        push(MG,  G, R, 1'b0, 1);
        push(MY,  Y, R, 1'b0, 4);
        push(AR1, R, R, 1'b0, 2);
        push(PW,  R, R, 1'b1, 1);
        push(AR2, R, R, 1'b0, 5);
        push(MG,  G, R, 1'b0, 1);
        for (int k = 1; k <= 32; k++) begin
            ped_req = (k <= 7);
            @(negedge Clock);
            if (k == 7) chk("ped_pend_kept", int'(dut.ped_pend), 1);
        end
        chk("ped_pend_cleared", int'(dut.ped_pend), 0);
        check_idle("ped_held_after");
        drained("t6_drain");
`else
        // Without the pedestrian option, ped_req has no effect
        reset_dut();
        for (int k = 1; k <= 20; k++) begin
            ped_req = (k <= 9);
            @(negedge Clock);
            if (k % 4 == 0) check_idle("ped_ignored");
        end
        drained("no_ped_drain");
`endif

        @(negedge Clock);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
